// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Holds the forwarding select codes, the legal branch-resolve stages and the scoreboard slot layout.
// Provides the writer/reader match helper used by the forwarding muxes.
package hazard_ctrl_pkg;

  // EX operand source select codes
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Legal BRANCH_STAGE values
  localparam int BR_STAGE_EX  = 2;
  localparam int BR_STAGE_MEM = 3;

  // Slot address fields are sized for the widest supported register file;
  // narrower ADDR_W inputs are zero-extended on entry.
  localparam int MAX_ADDR_W = 8;
  typedef logic [MAX_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      v;
    reg_addr_t dst;
    logic      regwrite;
    logic      memread;
    reg_addr_t rs;
    reg_addr_t rt;
    logic      use_rs;
    logic      use_rt;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // True when writer slot w produces register r that a reader actually uses.
  // Register 0 is hardwired zero and never counts as produced.
  function automatic logic writes_reg(input slot_t w, input reg_addr_t r, input logic use_r);
    return w.v & w.regwrite & (w.dst != '0) & use_r & (r == w.dst);
  endfunction

  // Operand source for the instruction in EX; the younger MEM result wins over WB.
  function automatic logic [1:0] fwd_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                         input logic use_r, input reg_addr_t r);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex.v && writes_reg(mem, r, use_r)) begin
      sel = FWD_MEM;
    end else if (ex.v && writes_reg(wb, r, use_r)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter.
// Latency: count_o reflects an inc_i cycle after the next rising edge.
// No backpressure: holds at all-ones once reached; asynchronous clear on rst_n low.
module sat_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next value: step on inc_i unless already at the top
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline: scoreboard of EX/MEM/WB writers.
// Latency: stall/flush/forward outputs are combinational from the scoreboard and current ID inputs.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle; a taken branch overrides stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int BRANCH_STAGE = BR_STAGE_MEM,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [ADDR_W-1:0] id_dst_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_jump_i,
  input  logic              branch_taken_i,
  output logic              stall_pc_o,
  output logic              stall_ifid_o,
  output logic              bubble_idex_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              flush_exmem_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  // Any value other than MEM resolves branches in EX
  localparam logic BR_MEM = (BRANCH_STAGE == BR_STAGE_MEM);

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, mem_d, wb_d;
  slot_t id_slot;

  reg_addr_t id_rs, id_rt, id_dst;
  logic      load_use;
  logic      stall;
  logic      jump_flush;
  logic      flush_ifid, flush_idex, flush_exmem;
  logic      any_flush;
  logic      wb_unused;

  assign id_rs  = reg_addr_t'(id_rs_i);
  assign id_rt  = reg_addr_t'(id_rt_i);
  assign id_dst = reg_addr_t'(id_dst_i);

  // Pack the ID-stage instruction into a scoreboard slot
  always_comb begin
    id_slot          = '0;
    id_slot.v        = id_valid_i;
    id_slot.dst      = id_dst;
    id_slot.regwrite = id_regwrite_i;
    id_slot.memread  = id_memread_i;
    id_slot.rs       = id_rs;
    id_slot.rt       = id_rt;
    id_slot.use_rs   = id_use_rs_i;
    id_slot.use_rt   = id_use_rt_i;
  end

  // Hazard detection and priority: taken branch (older) beats load-use stall and jump
  always_comb begin
    load_use = id_valid_i & ex_q.v & ex_q.memread & (ex_q.dst != '0) &
               ((id_use_rs_i & (id_rs == ex_q.dst)) | (id_use_rt_i & (id_rt == ex_q.dst)));
    stall       = load_use & ~branch_taken_i;
    // A jump waiting behind a stall is re-presented and flushes once the stall clears
    jump_flush  = id_valid_i & id_jump_i & ~load_use;
    flush_ifid  = branch_taken_i | jump_flush;
    flush_idex  = branch_taken_i;
    flush_exmem = branch_taken_i & BR_MEM;
    any_flush   = flush_ifid | flush_idex | flush_exmem;
  end

  // Scoreboard advance: stall or branch injects a bubble into EX; a MEM-resolved branch also kills EX
  always_comb begin
    ex_d  = (branch_taken_i || stall) ? '0 : id_slot;
    mem_d = (branch_taken_i && BR_MEM) ? '0 : ex_q;
    wb_d  = mem_q;
  end

  // Scoreboard registers, invalidated immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  // The WB slot only feeds forwarding through dst/regwrite/v
  assign wb_unused = ^{wb_q.memread, wb_q.rs, wb_q.rt, wb_q.use_rs, wb_q.use_rt};

  // Outputs are forced low while reset is held so the pipeline sees no stale redirect
  assign stall_pc_o    = rst_n & stall;
  assign stall_ifid_o  = rst_n & stall;
  assign bubble_idex_o = rst_n & stall;
  assign flush_ifid_o  = rst_n & flush_ifid;
  assign flush_idex_o  = rst_n & flush_idex;
  assign flush_exmem_o = rst_n & flush_exmem;
  assign fwd_a_o       = rst_n ? fwd_sel(ex_q, mem_q, wb_q, ex_q.use_rs, ex_q.rs) : FWD_RF;
  assign fwd_b_o       = rst_n ? fwd_sel(ex_q, mem_q, wb_q, ex_q.use_rt, ex_q.rt) : FWD_RF;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (stall_pc_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (any_flush & rst_n),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MEM-resolve, EX-resolve, 2-bit counters) share one stimulus.
// Table rows carry expected outputs; they are queued at drive time and popped when sampled.
// Hand-written sequence covers asynchronous reset in the middle of a stall.
module tb_hazard_ctrl;

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       rw, mr, j, br;
    logic       st, fi, fx, fm3, fm2;
    logic [1:0] fa, fb;
  } vec_t;

  typedef struct {
    logic        st, fi, fx, fm;
    logic [1:0]  fa, fb;
    logic [15:0] sc, fc;
  } exp_t;

  typedef struct {
    logic        spc, sif, bub, fi, fx, fm;
    logic [1:0]  fa, fb;
    logic [15:0] sc, fc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_jump, branch_taken;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        spc3, sif3, bub3, fi3, fx3, fm3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fc3;
  logic        spc2, sif2, bub2, fi2, fx2, fm2;
  logic [1:0]  fa2, fb2;
  logic [15:0] sc2, fc2;
  logic        spcc, sifc, bubc, fic, fxc, fmc;
  logic [1:0]  fac, fbc;
  logic [1:0]  scc, fcc;

  obs_t o3, o2, oc;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  initial forever #5 clk = ~clk;

  hazard_ctrl #(.ADDR_W(5), .BRANCH_STAGE(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_jump_i(id_jump),
    .branch_taken_i(branch_taken), .stall_pc_o(spc3), .stall_ifid_o(sif3),
    .bubble_idex_o(bub3), .flush_ifid_o(fi3), .flush_idex_o(fx3), .flush_exmem_o(fm3),
    .fwd_a_o(fa3), .fwd_b_o(fb3), .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  hazard_ctrl #(.ADDR_W(5), .BRANCH_STAGE(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_jump_i(id_jump),
    .branch_taken_i(branch_taken), .stall_pc_o(spc2), .stall_ifid_o(sif2),
    .bubble_idex_o(bub2), .flush_ifid_o(fi2), .flush_idex_o(fx2), .flush_exmem_o(fm2),
    .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  hazard_ctrl #(.ADDR_W(5), .BRANCH_STAGE(3), .CNT_W(2)) dutc (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_jump_i(id_jump),
    .branch_taken_i(branch_taken), .stall_pc_o(spcc), .stall_ifid_o(sifc),
    .bubble_idex_o(bubc), .flush_ifid_o(fic), .flush_idex_o(fxc), .flush_exmem_o(fmc),
    .fwd_a_o(fac), .fwd_b_o(fbc), .stall_cnt_o(scc), .flush_cnt_o(fcc));

  // Gather each instance's outputs into one record
  always_comb begin
    o3 = '{spc3, sif3, bub3, fi3, fx3, fm3, fa3, fb3, sc3, fc3};
    o2 = '{spc2, sif2, bub2, fi2, fx2, fm2, fa2, fb2, sc2, fc2};
    oc = '{spcc, sifc, bubc, fic, fxc, fmc, fac, fbc, {14'd0, scc}, {14'd0, fcc}};
  end

  function automatic vec_t mk(input int v, rs, rt, urs, urt, dst, rw, mr, j, br,
                              input int st, fi, fx, f3, f2, fa, fb);
    vec_t r;
    r.v = 1'(v);  r.rs = 5'(rs);  r.rt = 5'(rt);  r.urs = 1'(urs);  r.urt = 1'(urt);
    r.dst = 5'(dst);  r.rw = 1'(rw);  r.mr = 1'(mr);  r.j = 1'(j);  r.br = 1'(br);
    r.st = 1'(st);  r.fi = 1'(fi);  r.fx = 1'(fx);  r.fm3 = 1'(f3);  r.fm2 = 1'(f2);
    r.fa = 2'(fa);  r.fb = 2'(fb);
    return r;
  endfunction

  function automatic vec_t idle(input int fa, input int fb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb);
  endfunction

  function automatic int sat3(input int x);
    return (x > 3) ? 3 : x;
  endfunction

  task automatic drive(input vec_t r);
    id_valid = r.v;  id_rs = r.rs;  id_rt = r.rt;  id_use_rs = r.urs;  id_use_rt = r.urt;
    id_dst = r.dst;  id_regwrite = r.rw;  id_memread = r.mr;  id_jump = r.j;
    branch_taken = r.br;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t a, input exp_t e);
    chk({tag, ".stall_pc"},    16'(a.spc), 16'(e.st));
    chk({tag, ".stall_ifid"},  16'(a.sif), 16'(e.st));
    chk({tag, ".bubble_idex"}, 16'(a.bub), 16'(e.st));
    chk({tag, ".flush_ifid"},  16'(a.fi),  16'(e.fi));
    chk({tag, ".flush_idex"},  16'(a.fx),  16'(e.fx));
    chk({tag, ".flush_exmem"}, 16'(a.fm),  16'(e.fm));
    chk({tag, ".fwd_a"},       16'(a.fa),  16'(e.fa));
    chk({tag, ".fwd_b"},       16'(a.fb),  16'(e.fb));
    chk({tag, ".stall_cnt"},   a.sc,       e.sc);
    chk({tag, ".flush_cnt"},   a.fc,       e.fc);
  endtask

  function automatic exp_t mk_exp(input vec_t r, input logic fm, input int sc, input int fc);
    exp_t e;
    e.st = r.st;  e.fi = r.fi;  e.fx = r.fx;  e.fm = fm;  e.fa = r.fa;  e.fb = r.fb;
    e.sc = 16'(sc);  e.fc = 16'(fc);
    return e;
  endfunction

  // Watchdog: the run is fixed-length, this only guards against a hung simulator
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

  initial begin
    int   sc_m, fc_m;
    exp_t zero;
    zero = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 16'd0};

    // Reset / idle
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // lw $2 ; add $3,$2,$4 -> one stall, then fwd_a=WB in add's EX cycle
    tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(2, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // add $5 ; sub $6,$5,$5 -> both operands from EX/MEM
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // two writers of $5, then reader: MEM beats WB
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3, 4, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 9, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // add $5 ; nop ; or $7,$5,$0 -> fwd_a=WB, fwd_b=RF
    tbl.push_back(mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(2, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // lw $0 ; reader of $0 -> no stall, no forward
    tbl.push_back(mk(1, 1, 2, 1, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // branch taken while load-use present: flushes win, no stall
    tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 1,  0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // jump in ID during load-use stall: flush_ifid only once stall clears
    tbl.push_back(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(2, 0));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));
    // three more load-use stalls (five total) to saturate the 2-bit counter
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 9, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 9, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(0, 2));
    tbl.push_back(idle(0, 0));
    tbl.push_back(idle(0, 0));

    rst_n = 1'b0;
    drive(idle(0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    sc_m = 0;
    fc_m = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb_q.push_back(mk_exp(tbl[i], tbl[i].fm3, sc_m, fc_m));
      sb_q.push_back(mk_exp(tbl[i], tbl[i].fm2, sc_m, fc_m));
      sb_q.push_back(mk_exp(tbl[i], tbl[i].fm3, sat3(sc_m), sat3(fc_m)));
      #2;
      chk_obs($sformatf("row%0d/bs3", i), o3, sb_q.pop_front());
      chk_obs($sformatf("row%0d/bs2", i), o2, sb_q.pop_front());
      chk_obs($sformatf("row%0d/cnt2", i), oc, sb_q.pop_front());
      sc_m += int'(tbl[i].st);
      fc_m += int'(tbl[i].fi | tbl[i].fx | tbl[i].fm3);
    end

    // Asynchronous reset in the middle of a load-use stall
    @(negedge clk);
    drive(mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 2, 4, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("midrst.pre.stall_pc", 16'(o3.spc), 16'd1);
    chk("midrst.pre.stall_cnt", o3.sc, 16'(sc_m));
    chk("midrst.pre.stall_cnt_sat", oc.sc, 16'(sat3(sc_m)));
    chk("midrst.pre.flush_cnt", o3.fc, 16'(fc_m));
    #1;
    branch_taken = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_obs("midrst.async/bs3", o3, zero);
    chk_obs("midrst.async/bs2", o2, zero);
    chk_obs("midrst.async/cnt2", oc, zero);
    @(negedge clk);
    drive(idle(0, 0));
    rst_n = 1'b1;
    #2;
    chk_obs("midrst.after/bs3", o3, zero);
    chk_obs("midrst.after/cnt2", oc, zero);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
